// File: rtl/i2s_sample_tx.sv
// rtl/i2s_sample_tx.sv - I2S serialiser for signed stereo samples
// One-sample holding register feeding a frame-wide shift stage; flags underrun at frame start.
module i2s_sample_tx #(
    parameter int WIDTH      = 24,
    parameter int BCLK_DIV   = 4,
    parameter int FRAME_BITS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_bclk,
    output logic             o_lrclk,
    output logic             o_sdata,
    output logic             o_underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int K_W   = $clog2(2 * FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(2 * FRAME_BITS - 1);
    localparam logic [K_W-1:0]   K_HALF   = K_W'(FRAME_BITS);
    localparam logic [K_W-1:0]   J_LAST   = K_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div;
    logic             half;
    logic [K_W-1:0]   k;
    logic [K_W-1:0]   j;
    logic [WIDTH-1:0] hold_l;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] sh_l;
    logic [WIDTH-1:0] sh_r;
    logic             full;
    logic             underrun;
    logic             active;
    logic             lr;
    logic             slot_end;
    logic             wrap;
    logic             data_slot;
    logic             load;

    assign active    = (state != IDLE);
    assign lr        = (k >= K_HALF);
    assign j         = lr ? (k - K_HALF) : k;
    assign slot_end  = half && (div == DIV_MAX);
    assign wrap      = slot_end && (k == K_LAST);
    // Slot 0 of each half is the one-BCLK I2S delay; slots past WIDTH are zero padding.
    assign data_slot = (j >= K_W'(1)) && (j <= J_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (i_en && full) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (i_en) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (!i_en) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (i_en) begin
                    state_nxt = RUN;
                    load      = wrap;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div      <= '0;
            half     <= 1'b0;
            k        <= '0;
            full     <= 1'b0;
            hold_l   <= '0;
            hold_r   <= '0;
            sh_l     <= '0;
            sh_r     <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= load && !full;

            // An underrun load can coincide with an accept; the accept wins so the new sample is kept.
            if (i_valid && !full) begin
                hold_l <= i_left;
                hold_r <= i_right;
                full   <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end

            if (load) begin
                sh_l <= full ? hold_l : '0;
                sh_r <= full ? hold_r : '0;
            end else if (active && slot_end && data_slot) begin
                if (lr) begin
                    sh_r <= sh_r << 1;
                end else begin
                    sh_l <= sh_l << 1;
                end
            end

            if (!active) begin
                div  <= '0;
                half <= 1'b0;
                k    <= '0;
            end else if (div == DIV_MAX) begin
                div  <= '0;
                half <= ~half;
                if (half) begin
                    k <= wrap ? '0 : (k + K_W'(1));
                end
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    assign o_ready    = ~full;
    assign o_underrun = underrun;
    assign o_bclk     = active && half;
    assign o_lrclk    = active && lr;
    assign o_sdata    = active && data_slot && (lr ? sh_r[WIDTH-1] : sh_l[WIDTH-1]);

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb/tb_i2s_sample_tx.sv - directed bench for i2s_sample_tx
// WIDTH=24, BCLK_DIV=2, FRAME_BITS=32: one frame = 64 slots of 4 clocks.
module tb_i2s_sample_tx;

    localparam int WIDTH      = 24;
    localparam int BCLK_DIV   = 2;
    localparam int FRAME_BITS = 32;
    localparam logic [191:0] CLK_EXP = {64'hFFFF_FFFF_0000_0000, 64'h0, {64{1'b1}}};

    logic             clk;
    logic             i_rst;
    logic             i_en;
    logic [WIDTH-1:0] i_left;
    logic [WIDTH-1:0] i_right;
    logic             i_valid;
    logic             o_ready;
    logic             o_bclk;
    logic             o_lrclk;
    logic             o_sdata;
    logic             o_underrun;

    int total;
    int bad;

    logic [23:0] feed_l [8];
    logic [23:0] feed_r [8];
    int          feed_idx;
    int          feed_cnt;

    logic [63:0] cap_sd;
    logic [63:0] cap_lr;
    logic [63:0] cap_blo;
    logic [63:0] cap_bhi;
    int          cap_unstable;
    int          cap_under;
    int          cap_ready;

    i2s_sample_tx #(
        .WIDTH(WIDTH),
        .BCLK_DIV(BCLK_DIV),
        .FRAME_BITS(FRAME_BITS)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_en(i_en),
        .i_left(i_left),
        .i_right(i_right),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_bclk(o_bclk),
        .o_lrclk(o_lrclk),
        .o_sdata(o_sdata),
        .o_underrun(o_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] exp_sd(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] v;
        int jj;
        v = '0;
        for (int kk = 0; kk < 64; kk++) begin
            jj = kk % 32;
            if (jj >= 1 && jj <= 24) v[kk] = (kk < 32) ? l[24-jj] : r[24-jj];
        end
        return v;
    endfunction

    task automatic do_reset();
        i_rst   = 1'b1;
        i_en    = 1'b0;
        i_valid = 1'b0;
        i_left  = '0;
        i_right = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic advance();
        feed_idx++;
        if (feed_idx < feed_cnt) begin
            i_left  = feed_l[feed_idx];
            i_right = feed_r[feed_idx];
        end else begin
            i_valid = 1'b0;
        end
    endtask

    // Accept sample 0 at the next edge, enter RUN at the edge after; returns just before slot 0.
    task automatic start_stream();
        feed_idx = 0;
        i_left   = feed_l[0];
        i_right  = feed_r[0];
        i_valid  = 1'b1;
        i_en     = 1'b1;
        @(posedge clk); #1;
        advance();
        @(posedge clk); #1;
    endtask

    task automatic capture_frame(input int off_slot, input int on_slot);
        int s;
        int c;
        logic fire;
        cap_unstable = 0;
        cap_under    = 0;
        cap_ready    = 0;
        for (int n = 0; n < 256; n++) begin
            if (n == off_slot * 4) i_en = 1'b0;
            if (n == on_slot * 4) i_en = 1'b1;
            @(negedge clk);
            s = n / 4;
            c = n % 4;
            if (c == 0) cap_blo[s] = o_bclk;
            if (c == 1) begin
                cap_sd[s]  = o_sdata;
                cap_lr[s]  = o_lrclk;
                if (o_bclk !== cap_blo[s]) cap_unstable++;
            end
            if (c == 2) cap_bhi[s] = o_bclk;
            if (c >= 2 && (o_sdata !== cap_sd[s] || o_lrclk !== cap_lr[s])) cap_unstable++;
            if (c == 3 && o_bclk !== cap_bhi[s]) cap_unstable++;
            if (o_underrun) cap_under++;
            if (o_ready) cap_ready++;
            fire = i_valid && o_ready;
            @(posedge clk); #1;
            if (fire) advance();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (o_bclk !== 1'b0) begin bad++; $display("FAIL rst_bclk got=%b exp=0", o_bclk); end
        total++; if (o_lrclk !== 1'b0) begin bad++; $display("FAIL rst_lrclk got=%b exp=0", o_lrclk); end
        total++; if (o_sdata !== 1'b0) begin bad++; $display("FAIL rst_sdata got=%b exp=0", o_sdata); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
        total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%b exp=0", o_underrun); end
    endtask

    task automatic test_single_sample();
        do_reset();
        feed_l[0] = 24'h800001;
        feed_r[0] = 24'h7FFFFF;
        feed_cnt  = 1;
        start_stream();
        capture_frame(-1, -1);
        total++; if (cap_sd !== 64'h01FF_FFFC_0100_0002) begin bad++; $display("FAIL single_sdata got=%h exp=%h", cap_sd, 64'h01FF_FFFC_0100_0002); end
        total++; if ({cap_lr, cap_blo, cap_bhi} !== CLK_EXP) begin bad++; $display("FAIL single_clocks got=%h exp=%h", {cap_lr, cap_blo, cap_bhi}, CLK_EXP); end
        total++; if (cap_unstable !== 0) begin bad++; $display("FAIL single_stable got=%0d exp=0", cap_unstable); end
        total++; if (cap_under !== 0) begin bad++; $display("FAIL single_underrun got=%0d exp=0", cap_under); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        feed_l[0] = 24'h123456; feed_r[0] = 24'h654321;
        feed_l[1] = 24'hA5A5A5; feed_r[1] = 24'h5A5A5A;
        feed_l[2] = 24'h000001; feed_r[2] = 24'hFFFFFE;
        feed_l[3] = 24'h7FFFFF; feed_r[3] = 24'h800000;
        feed_cnt  = 4;
        start_stream();
        for (int f = 0; f < 4; f++) begin
            capture_frame(-1, -1);
            total++; if (cap_sd !== exp_sd(feed_l[f], feed_r[f])) begin bad++; $display("FAIL b2b_sdata[%0d] got=%h exp=%h", f, cap_sd, exp_sd(feed_l[f], feed_r[f])); end
            total++; if ({cap_lr, cap_blo, cap_bhi} !== CLK_EXP) begin bad++; $display("FAIL b2b_clocks[%0d] got=%h exp=%h", f, {cap_lr, cap_blo, cap_bhi}, CLK_EXP); end
            total++; if (cap_unstable !== 0) begin bad++; $display("FAIL b2b_stable[%0d] got=%0d exp=0", f, cap_unstable); end
            total++; if (cap_under !== 0) begin bad++; $display("FAIL b2b_underrun[%0d] got=%0d exp=0", f, cap_under); end
            if (f < 3) begin
                total++; if (cap_ready !== 1) begin bad++; $display("FAIL b2b_ready_cycles[%0d] got=%0d exp=1", f, cap_ready); end
            end
        end
    endtask

    // Continues straight on from test_back_to_back with the feed exhausted.
    task automatic test_underrun();
        capture_frame(-1, -1);
        total++; if (cap_sd !== 64'h0) begin bad++; $display("FAIL under_sdata got=%h exp=0", cap_sd); end
        total++; if (cap_under !== 1) begin bad++; $display("FAIL under_pulses got=%0d exp=1", cap_under); end
        total++; if ({cap_lr, cap_blo, cap_bhi} !== CLK_EXP) begin bad++; $display("FAIL under_clocks got=%h exp=%h", {cap_lr, cap_blo, cap_bhi}, CLK_EXP); end
    endtask

    task automatic test_drain();
        int nz;
        do_reset();
        feed_l[0] = 24'hC0FFEE; feed_r[0] = 24'h0BEEF1;
        feed_l[1] = 24'h13579B; feed_r[1] = 24'hECA864;
        feed_l[2] = 24'hF0F0F0; feed_r[2] = 24'h0F0F0F;
        feed_cnt  = 3;
        start_stream();
        capture_frame(10, 40);
        total++; if (cap_sd !== exp_sd(feed_l[0], feed_r[0])) begin bad++; $display("FAIL drain_resume_sdata got=%h exp=%h", cap_sd, exp_sd(feed_l[0], feed_r[0])); end
        total++; if ({cap_lr, cap_blo, cap_bhi} !== CLK_EXP) begin bad++; $display("FAIL drain_resume_clocks got=%h exp=%h", {cap_lr, cap_blo, cap_bhi}, CLK_EXP); end
        capture_frame(10, -1);
        total++; if (cap_sd !== exp_sd(feed_l[1], feed_r[1])) begin bad++; $display("FAIL drain_last_sdata got=%h exp=%h", cap_sd, exp_sd(feed_l[1], feed_r[1])); end
        total++; if (cap_under !== 0) begin bad++; $display("FAIL drain_underrun got=%0d exp=0", cap_under); end
        nz = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (o_bclk || o_lrclk || o_sdata || o_underrun) nz++;
            @(posedge clk); #1;
        end
        total++; if (nz !== 0) begin bad++; $display("FAIL drain_idle_outputs got=%0d nonzero cycles exp=0", nz); end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL drain_hold_ready got=%b exp=0", o_ready); end
        i_en = 1'b1;
        @(posedge clk); #1;
        capture_frame(-1, -1);
        total++; if (cap_sd !== exp_sd(feed_l[2], feed_r[2])) begin bad++; $display("FAIL drain_retained_sdata got=%h exp=%h", cap_sd, exp_sd(feed_l[2], feed_r[2])); end
    endtask

    task automatic test_reset_mid();
        int nz;
        int pulses;
        do_reset();
        feed_l[0] = 24'hFFFFFF; feed_r[0] = 24'hFFFFFF;
        feed_l[1] = 24'h111111; feed_r[1] = 24'h222222;
        feed_cnt  = 2;
        start_stream();
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int n = 1; n < 80; n++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (o_sdata !== 1'b1) begin bad++; $display("FAIL mid_pre_sdata got=%b exp=1", o_sdata); end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL mid_pre_ready got=%b exp=0", o_ready); end
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        total++; if ({o_bclk, o_lrclk, o_sdata} !== 3'b000) begin bad++; $display("FAIL mid_rst_outputs got=%b exp=000", {o_bclk, o_lrclk, o_sdata}); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", o_ready); end
        nz = 0;
        pulses = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_bclk || o_lrclk || o_sdata) nz++;
            if (o_underrun) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_rst_underrun got=%0d exp=0", pulses); end
        total++; if (nz !== 0) begin bad++; $display("FAIL mid_rst_idle got=%0d nonzero cycles exp=0", nz); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        feed_idx = 0;
        feed_cnt = 0;
        i_rst    = 1'b1;
        i_en     = 1'b0;
        i_valid  = 1'b0;
        i_left   = '0;
        i_right  = '0;
        test_reset();
        test_single_sample();
        test_back_to_back();
        test_underrun();
        test_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
